// File: rtl/itoa_stream_if.sv
// itoa_stream_if: request and byte-stream handshake bundle for itoa_stream.
// The master side drives the integer request and accepts bytes.
// The slave side is the converter.
interface itoa_stream_if;
  // Request side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  // ASCII byte stream side
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  // Status
  logic        busy;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/itoa_stream.sv
// itoa_stream: converts one 32-bit integer into decimal ASCII bytes.
// Digits are produced LSB-first, one per cycle, by a reciprocal-multiply divide
// by 10. They are stacked and then streamed MSB-first over a valid/ready
// handshake. A leading '-' is sent for negative signed inputs. Leading zeros
// pad the output up to MIN_DIGITS.
// Optional feature macro: ITOA_TRAIL_NL_EN. When defined, a trailing LF (0x0A)
// follows the digits and carries out_last instead of the final digit.
module itoa_stream #(
  parameter int MIN_DIGITS = 1          // 1..10
) (
  input  logic          clk,
  input  logic          rstn,
  itoa_stream_if.slave  bus
);

  localparam logic [3:0] MIN_D       = 4'(MIN_DIGITS);
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
`ifdef ITOA_TRAIL_NL_EN
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic       LAST_ON_DIGIT = 1'b0;
`else
  localparam logic       LAST_ON_DIGIT = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_SIGN = 3'd2,
`ifdef ITOA_TRAIL_NL_EN
    S_EMIT = 3'd3,
    S_NL   = 3'd4
`else
    S_EMIT = 3'd3
`endif
  } state_t;

  state_t      state_q;
  logic [31:0] x_q;          // remaining value still to be divided
  logic        neg_q;        // a '-' must precede the digits
  logic [3:0]  cnt_q;        // number of digits currently on the stack
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        out_last_q;

  // Ten entries are enough for the largest 32-bit value (4294967295).
  logic [3:0]  stack_q [0:9];

  logic [31:0] mag;
  logic [31:0] q_est;
  logic [31:0] r_raw;
  logic [31:0] q_corr;
  logic [3:0]  digit;
  logic [3:0]  cnt_inc;
  logic [3:0]  top_idx;
  logic [3:0]  below_idx;
  logic        conv_done;
  logic        out_fire;

  // Magnitude of the request: two's-complement negate when signed and negative.
  // 0x80000000 negates to itself, which read as unsigned is 2147483648.
  assign mag = (bus.in_signed && bus.in_data[31]) ? (~bus.in_data + 32'd1)
                                                  : bus.in_data;

  assign cnt_inc   = cnt_q + 4'd1;
  assign top_idx   = cnt_q - 4'd1;
  assign below_idx = cnt_q - 4'd2;
  assign out_fire  = out_valid_q & bus.out_ready;

  // Divide x by 10 with a reciprocal multiply.
  // The remainder is fixed up so the digit is always 0..9.
  always_comb begin
    q_est  = 32'(({32'd0, x_q} * 64'h0000_0000_CCCC_CCCD) >> 35);
    r_raw  = x_q - q_est * 32'd10;
    q_corr = q_est;
    digit  = 4'(r_raw);
    if (r_raw >= 32'd10) begin
      q_corr = q_est + 32'd1;
      digit  = 4'(r_raw - 32'd10);
    end
  end

  // Conversion stops once the value is exhausted and enough digits are stacked.
  assign conv_done = (q_corr == 32'd0) && (cnt_inc >= MIN_D);

  // Digit stack storage: written while converting, read MSB-first by the FSM.
  always_ff @(posedge clk) begin
    if (state_q == S_CONV) begin
      stack_q[cnt_q] <= digit;
    end
  end

  // Control FSM with registered byte outputs.
  // The first byte is loaded on the final conversion edge, so n digits give n
  // cycles of latency whether or not a sign byte leads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      x_q         <= 32'd0;
      neg_q       <= 1'b0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_q     <= mag;
            neg_q   <= bus.in_signed & bus.in_data[31];
            cnt_q   <= 4'd0;
            state_q <= S_CONV;
          end
        end

        S_CONV: begin
          x_q   <= q_corr;
          cnt_q <= cnt_inc;
          if (conv_done) begin
            out_valid_q <= 1'b1;
            if (neg_q) begin
              out_data_q <= ASCII_MINUS;
              out_last_q <= 1'b0;
              state_q    <= S_SIGN;
            end else begin
              // The digit just computed is the most significant one.
              out_data_q <= {4'h3, digit};
              out_last_q <= LAST_ON_DIGIT && (cnt_q == 4'd0);
              state_q    <= S_EMIT;
            end
          end
        end

        S_SIGN: begin
          if (out_fire) begin
            out_data_q <= {4'h3, stack_q[top_idx]};
            out_last_q <= LAST_ON_DIGIT && (cnt_q == 4'd1);
            state_q    <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (out_fire) begin
            cnt_q <= top_idx;
            if (cnt_q == 4'd1) begin
`ifdef ITOA_TRAIL_NL_EN
              out_data_q <= ASCII_LF;
              out_last_q <= 1'b1;
              state_q    <= S_NL;
`else
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= S_IDLE;
`endif
            end else begin
              out_data_q <= {4'h3, stack_q[below_idx]};
              out_last_q <= LAST_ON_DIGIT && (cnt_q == 4'd2);
            end
          end
        end

`ifdef ITOA_TRAIL_NL_EN
        S_NL: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
`endif

        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: doc/itoa_stream.md
Name: itoa_stream

Overview:
- Sequential binary-to-decimal-ASCII converter that feeds the console/UART TX byte path.
- Takes one 32-bit integer per transaction and repeatedly applies the divide-by-10 / multiply-by-10 pair to extract decimal digits.
- Buffers the digits LSB-first in an internal digit stack, then streams them MSB-first as ASCII bytes over a valid/ready handshake.
- Used by the integer print path: the core hands it a register value and it drains bytes into the TX FIFO.

Parameters:
MIN_DIGITS, 1, minimum number of digits emitted; leading zeros are padded up to this count; legal range 1..10.

Ports:
clk        input   1   system clock, all state updates on rising edge
rstn       input   1   asynchronous active-low reset
in_valid   input   1   request: in_data/in_signed are valid
in_ready   output  1   block idle and able to accept a request
in_data    input   32  integer to convert
in_signed  input   1   1: treat in_data as two's-complement signed; 0: unsigned
out_valid  output  1   out_data holds a byte to transfer
out_ready  input   1   downstream accepts out_data this cycle
out_data   output  8   ASCII byte ('0'..'9' = 0x30..0x39, '-' = 0x2D, LF = 0x0A)
out_last   output  1   qualifies the final byte of the current number
busy       output  1   high from request acceptance until the last byte is accepted

Behaviour:
- Clock and reset: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values:
  - in_ready=1, out_valid=0, out_data=0x00, out_last=0, busy=0.
  - State is IDLE; digit stack count is 0.
  - Asserting rstn mid-operation aborts immediately: out_valid drops asynchronously and no partial bytes are emitted after release.
- State machine: IDLE -> CONV -> SIGN (optional) -> EMIT -> [NL] -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, capture the magnitude and go to CONV.
  - Magnitude is in_data when in_signed=0 or in_data[31]=0; otherwise it is -in_data, taken modulo 2^32 as unsigned.
  - 0x80000000 with in_signed=1 gives magnitude 2147483648.
  - Capture neg = in_signed & in_data[31].
- CONV: one digit per cycle.
  - q = floor(x/10), r = x - 10*q; r must be exactly 0..9.
  - A reciprocal-multiply quotient must be corrected: if r>=10 then q+=1 and r-=10.
  - Push r onto the stack and set x <= q.
  - Leave CONV when the new x==0 and the stack count >= MIN_DIGITS.
  - Value 0 yields a single '0'.
  - Stack depth is 10; it never overflows because the maximum is 10 digits.
- Next state after CONV: SIGN if neg, else EMIT.
- SIGN: present '-' with out_valid=1 and hold it until out_ready, then go to EMIT.
- EMIT:
  - Present 0x30+top-of-stack and pop on out_valid & out_ready.
  - out_last=1 on the final digit, unless the LF byte is enabled.
  - After the last pop, return to IDLE on the next edge.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never deasserts without a transfer, except on reset.
  - The downstream may hold out_ready high continuously: then one byte transfers per cycle with no bubbles between bytes of one number.
- Timing:
  - in_ready=0 and busy=1 in every state except IDLE.
  - A new request can be accepted the cycle after the last byte transfer.
  - Latency from acceptance to the first out_valid is n cycles for n digits, with no extra cycle for SIGN.
- Registers: out_data and out_valid are registered outputs; no combinational path runs from out_ready to out_valid.

Optional Feature:
- Macro: ITOA_TRAIL_NL_EN.
- When defined:
  - After the final digit, the NL state emits 0x0A.
  - out_last is asserted on the LF byte only, not on the final digit.
  - Total bytes per number = digits + neg + 1.
- When undefined:
  - The NL state and its logic are absent.
  - out_last marks the final digit.

Test Plan:
1. in_data=0, in_signed=0, MIN_DIGITS=1, out_ready=1 -> single byte 0x30 with out_last=1; busy falls the cycle after; in_ready returns.
2. in_data=0xFFFFFFFF, in_signed=0 -> bytes "4294967295" (0x34,0x32,...,0x35), 10 conversion cycles, no stack overflow; the same value with in_signed=1 -> "-1".
3. in_data=0x80000000, in_signed=1 -> "-2147483648" (11 bytes); with ITOA_TRAIL_NL_EN, 12 bytes ending 0x0A, out_last only on 0x0A.
4. in_data=1234567890, out_ready toggled randomly (50%) -> bytes "1234567890" in order; out_data and out_last stable while stalled; no drops or duplicates.
5. MIN_DIGITS=4, in_data=7 -> "0007"; in_data=12345 -> "12345" (no truncation).
6. in_data=987654, rstn asserted after 3 bytes have been accepted -> out_valid=0 immediately, in_ready=1 after release; a new request with in_data=42 yields exactly "42".
